div_seq_ctrl: RTL and testbench
===============================

Name: div_seq_ctrl

Overview:
- Multi-cycle sequencer that performs 32-bit integer division (MIPS DIV/DIVU semantics) using one shared add/subtract datapath.
- Iterates restoring division, one subtract-and-compare step per clock.
- Sits beside the ALU in the execute stage and feeds HI (remainder) and LO (quotient).
- The pipeline stalls on busy.

Parameters:
- WIDTH, 32: operand, quotient and remainder width. The iteration count equals WIDTH.

Ports:
- clk  input  1  system clock; rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request. Sampled only in IDLE.
- signed_op  input  1  1 = signed (DIV), 0 = unsigned (DIVU). Ignored unless DIV_SIGNED_EN is defined.
- dividend  input  WIDTH  numerator. Captured on the accepting edge.
- divisor  input  WIDTH  denominator. Captured on the accepting edge.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse; results are valid from this cycle on.
- quotient  output  WIDTH  LO result. Held until the next accepted start.
- remainder  output  WIDTH  HI result. Held until the next accepted start.
- div_by_zero  output  1  sticky flag for the last operation. Cleared on the next accepted start.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: state=IDLE; busy=0; done=0; quotient=0; remainder=0; div_by_zero=0; iteration counter=0.
- States:
  - IDLE -> ZERO if start=1 and divisor=0.
  - IDLE -> CALC if start=1 and divisor!=0.
  - CALC -> CALC while counter<WIDTH-1. The counter increments once per CALC cycle.
  - CALC -> FIX when counter=WIDTH-1.
  - FIX -> DONE.
  - ZERO -> DONE.
  - DONE -> IDLE, unconditionally.
- Accepting edge: the edge where start is sampled high in IDLE. On it, capture the operand magnitudes and the sign info, clear div_by_zero, and reset the counter to 0.
- CALC step:
  - trial = {rem[WIDTH-1:0], q[WIDTH-1]} - {0, divisor_mag}, computed as a (WIDTH+1)-bit subtract: invert B, cin=1.
  - If no borrow (trial bit WIDTH = 0): rem = trial[WIDTH-1:0] and shift 1 into q.
  - Otherwise: rem = shifted value (restore) and shift 0 into q.
- FIX: apply sign correction (see Optional Feature), then register quotient and remainder.
- ZERO: quotient = all ones, remainder = dividend, div_by_zero = 1. The CALC phase is skipped.
- done is high only in DONE.
- Latency, counted from the accepting edge E:
  - Normal operation: done is high during the cycle after edge E+WIDTH+2, i.e. 34 cycles for WIDTH=32.
  - Divide-by-zero: done is high after edge E+2.
- busy: high from edge E+1 until done is sampled. It is low again in the cycle after DONE.
- start while busy: ignored. No queuing and no effect on the operation in flight.
- start in the DONE cycle: ignored. A new start is accepted only in IDLE, so back-to-back issue has a one-cycle IDLE gap.
- Input changes: dividend and divisor may change after the accepting edge without affecting the result.
- Reset mid-operation: abort immediately to the reset values. No done pulse.
- Outputs: quotient and remainder change only in FIX, ZERO or reset. They are never driven with intermediate values.

Optional Feature:
- Macro: DIV_SIGNED_EN.
- Defined:
  - If signed_op=1, the operands are converted to magnitudes at accept (two's-complement negate when the MSB is set).
  - In FIX, quotient is negated if the operand signs differ, and remainder is negated if the dividend is negative. Quotient truncates toward zero; remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0, with no exception.
  - Divide-by-zero result is the same as unsigned.
- Not defined: signed_op is ignored, all operations are unsigned, and FIX only registers the results. Latency is unchanged.

Test Plan:
1. Unsigned 100 / 7 (start one cycle) -> done exactly 34 cycles after the accepting edge; quotient=14, remainder=2; busy high for 34 cycles.
2. 0xFFFFFFFF / 1, then 5 / 0xFFFFFFFF -> Q=0xFFFFFFFF, R=0; then Q=0, R=5; div_by_zero=0 both times.
3. 1234 / 0 -> done 2 cycles after accept; Q=0xFFFFFFFF, R=1234, div_by_zero=1. div_by_zero clears on the next accepted start.
4. DIV_SIGNED_EN, signed_op=1:
   - -7 / 2 -> Q=0xFFFFFFFD (-3), R=0xFFFFFFFF (-1).
   - 7 / -2 -> Q=-3, R=1.
   - 0x80000000 / -1 -> Q=0x80000000, R=0.
5. start pulsed during CALC, with dividend and divisor changed mid-operation -> ignored; the first result is unchanged and only one done pulse occurs.
6. reset asserted at CALC cycle 10 -> immediately busy=0, outputs=0, no done. Then 9 / 3 -> Q=3, R=0 with normal latency.

Source files
------------

// File: rtl/div_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : div_seq_ctrl
// Description : Multi-cycle 32-bit restoring divider sequencer (MIPS DIV/DIVU).
//               One subtract-and-compare step per clock on a single shared
//               (WIDTH+1)-bit adder; feeds HI (remainder) and LO (quotient).
//               Optional signed support is compiled in with DIV_SIGNED_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module div_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CALC = 3'd1,
    FIX  = 3'd2,
    ZERO = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t           state, state_next;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] dvs_r;
  logic             q_neg;
  logic             r_neg;

  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] shifted;

`ifdef DIV_SIGNED_EN
  // Convert signed operands to magnitudes and remember the result signs
  always_comb begin
    dvd_neg = signed_op & dividend[WIDTH-1];
    dvs_neg = signed_op & divisor[WIDTH-1];
    dvd_mag = dvd_neg ? (~dividend + ONE) : dividend;
    dvs_mag = dvs_neg ? (~divisor + ONE) : divisor;
  end
`else
  logic unused_signed_op;
  assign unused_signed_op = signed_op;

  // Unsigned-only build: operands pass straight through
  always_comb begin
    dvd_neg = 1'b0;
    dvs_neg = 1'b0;
    dvd_mag = dividend;
    dvs_mag = divisor;
  end
`endif

  // Shared datapath: shift partial remainder, subtract divisor via ~B + 1
  always_comb begin
    shifted = {rem_r[WIDTH-2:0], q_r[WIDTH-1]};
    trial   = {rem_r, q_r[WIDTH-1]} + {1'b1, ~dvs_r} + {{WIDTH{1'b0}}, 1'b1};
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic and status outputs
  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    done       = (state == DONE);
    case (state)
      IDLE: if (start) state_next = (divisor == '0) ? ZERO : CALC;
      CALC: if (count == LAST) state_next = FIX;
      FIX:  state_next = DONE;
      ZERO: state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, iteration, and result registration
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count       <= '0;
      rem_r       <= '0;
      q_r         <= '0;
      dvs_r       <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          count       <= '0;
          rem_r       <= '0;
          dvs_r       <= dvs_mag;
          // A zero divisor returns the raw dividend, so skip the magnitude
          q_r         <= (divisor == '0) ? dividend : dvd_mag;
          q_neg       <= dvd_neg ^ dvs_neg;
          r_neg       <= dvd_neg;
          div_by_zero <= 1'b0;
        end
        CALC: begin
          count <= count + CW'(1);
          q_r   <= {q_r[WIDTH-2:0], ~trial[WIDTH]};
          rem_r <= trial[WIDTH] ? shifted : trial[WIDTH-1:0];
        end
        FIX: begin
          quotient  <= q_neg ? (~q_r + ONE) : q_r;
          remainder <= r_neg ? (~rem_r + ONE) : rem_r;
        end
        ZERO: begin
          quotient    <= '1;
          remainder   <= q_r;
          div_by_zero <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_div_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_seq_ctrl
// Description : Scoreboard bench for div_seq_ctrl. Expected results are pushed
//               when an operation is issued and popped when done is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        signed_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  div_seq_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .signed_op(signed_op),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Reference model: MIPS DIV/DIVU results
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic sop);
    exp_t e;
    logic [31:0] ma, mb;
    logic na, nb;
`ifdef DIV_SIGNED_EN
    na = sop & a[31];
    nb = sop & b[31];
`else
    na = sop & 1'b0;
    nb = na;
`endif
    if (b == 32'd0) begin
      e.q = '1; e.r = a; e.dbz = 1'b1;
      return e;
    end
    ma = na ? -a : a;
    mb = nb ? -b : b;
    e.q = ma / mb;
    e.r = ma % mb;
    if (na ^ nb) e.q = -e.q;
    if (na) e.r = -e.r;
    e.dbz = 1'b0;
    return e;
  endfunction

  // Issue one operation from IDLE and wait (bounded) for done.
  // Inputs are scrambled right after the accepting edge; with inject set,
  // a start pulse with other operands is driven during CALC.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sop,
                        input bit inject, output int lat, output int busy_cnt,
                        output bit to, output logic dbz_acc);
    sb.push_back(model(a, b, sop));
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b; signed_op = sop;
    @(posedge clk);
    #1;
    start = 1'b0; dividend = $urandom; divisor = $urandom; signed_op = $urandom_range(0, 1);
    lat = 0; busy_cnt = 0; to = 1'b1; dbz_acc = 1'bx;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (k == 1) dbz_acc = div_by_zero;
      if (inject && k >= 5 && k <= 7) begin
        start = 1'b1; dividend = 32'd77; divisor = 32'd0;
      end else begin
        start = 1'b0;
      end
      if (busy) busy_cnt++;
      if (done) begin
        lat = k; to = 1'b0;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; signed_op = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 67'd0) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%b done=%b q=%h r=%h dbz=%b, want all zero",
               busy, done, quotient, remainder, div_by_zero);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic;
    int lat, bc; bit to; logic da; exp_t e;
    run_op(32'd100, 32'd7, 1'b0, 1'b0, lat, bc, to, da);
    e = sb.pop_front();
    n_checks++;
    if (to || lat != 34) begin n_fail++; $display("FAIL basic_latency: got %0d (timeout=%0b), want 34", lat, to); end
    n_checks++;
    if (bc != 34) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d, want 34", bc); end
    n_checks++;
    if (quotient !== e.q || remainder !== e.r) begin
      n_fail++; $display("FAIL basic_result: got q=%0d r=%0d, want q=%0d r=%0d", quotient, remainder, e.q, e.r);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_after_done: got done=%b busy=%b, want 0 0", done, busy);
    end
  endtask

  task automatic test_extremes;
    int lat, bc; bit to; logic da; exp_t e;
    logic [63:0] ops [2];
    ops[0] = {32'hFFFF_FFFF, 32'd1};
    ops[1] = {32'd5, 32'hFFFF_FFFF};
    foreach (ops[i]) begin
      run_op(ops[i][63:32], ops[i][31:0], 1'b0, 1'b0, lat, bc, to, da);
      e = sb.pop_front();
      n_checks++;
      if (to || quotient !== e.q || remainder !== e.r || div_by_zero !== e.dbz) begin
        n_fail++;
        $display("FAIL extreme_%0d: got q=%h r=%h dbz=%b to=%0b, want q=%h r=%h dbz=%b",
                 i, quotient, remainder, div_by_zero, to, e.q, e.r, e.dbz);
      end
    end
  endtask

  task automatic test_div_zero;
    int lat, bc; bit to; logic da; exp_t e;
    run_op(32'd1234, 32'd0, 1'b0, 1'b0, lat, bc, to, da);
    e = sb.pop_front();
    n_checks++;
    if (to || lat != 2) begin n_fail++; $display("FAIL dbz_latency: got %0d (timeout=%0b), want 2", lat, to); end
    n_checks++;
    if (quotient !== e.q || remainder !== e.r || div_by_zero !== 1'b1) begin
      n_fail++; $display("FAIL dbz_result: got q=%h r=%0d dbz=%b, want q=%h r=%0d dbz=1",
                         quotient, remainder, div_by_zero, e.q, e.r);
    end
    run_op(32'd50, 32'd5, 1'b0, 1'b0, lat, bc, to, da);
    e = sb.pop_front();
    n_checks++;
    if (da !== 1'b0) begin n_fail++; $display("FAIL dbz_clear_on_start: got %b, want 0", da); end
    n_checks++;
    if (to || quotient !== e.q || remainder !== e.r || div_by_zero !== 1'b0) begin
      n_fail++; $display("FAIL dbz_next_op: got q=%0d r=%0d dbz=%b, want q=%0d r=%0d dbz=0",
                         quotient, remainder, div_by_zero, e.q, e.r);
    end
  endtask

  task automatic test_signed;
    int lat, bc; bit to; logic da; exp_t e;
    logic [63:0] ops [3];
    ops[0] = {-32'sd7, 32'sd2};
    ops[1] = {32'sd7, -32'sd2};
    ops[2] = {32'h8000_0000, 32'hFFFF_FFFF};
    foreach (ops[i]) begin
      run_op(ops[i][63:32], ops[i][31:0], 1'b1, 1'b0, lat, bc, to, da);
      e = sb.pop_front();
      n_checks++;
      if (to || lat != 34 || quotient !== e.q || remainder !== e.r || div_by_zero !== e.dbz) begin
        n_fail++;
        $display("FAIL signed_%0d: got q=%h r=%h dbz=%b lat=%0d, want q=%h r=%h dbz=%b lat=34",
                 i, quotient, remainder, div_by_zero, lat, e.q, e.r, e.dbz);
      end
    end
  endtask

  task automatic test_start_while_busy;
    int lat, bc, extra; bit to; logic da; exp_t e;
    run_op(32'd1000, 32'd33, 1'b0, 1'b1, lat, bc, to, da);
    e = sb.pop_front();
    n_checks++;
    if (to || lat != 34 || quotient !== e.q || remainder !== e.r || div_by_zero !== 1'b0) begin
      n_fail++; $display("FAIL busy_start_result: got q=%0d r=%0d dbz=%b lat=%0d, want q=%0d r=%0d dbz=0 lat=34",
                         quotient, remainder, div_by_zero, lat, e.q, e.r);
    end
    extra = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) extra++;
    end
    n_checks++;
    if (extra != 0 || quotient !== e.q || remainder !== e.r) begin
      n_fail++; $display("FAIL busy_start_single_done: got %0d extra done, q=%0d r=%0d, want 0, q=%0d r=%0d",
                         extra, quotient, remainder, e.q, e.r);
    end
  endtask

  task automatic test_reset_mid;
    int lat, bc, seen; bit to; logic da; exp_t e;
    @(negedge clk);
    start = 1'b1; dividend = 32'd500; divisor = 32'd3; signed_op = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 67'd0) begin
      n_fail++; $display("FAIL reset_mid_abort: got busy=%b done=%b q=%h r=%h dbz=%b, want all zero",
                         busy, done, quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    n_checks++;
    if (seen != 0) begin n_fail++; $display("FAIL reset_mid_no_done: got %0d active cycles, want 0", seen); end
    run_op(32'd9, 32'd3, 1'b0, 1'b0, lat, bc, to, da);
    e = sb.pop_front();
    n_checks++;
    if (to || lat != 34 || quotient !== e.q || remainder !== e.r) begin
      n_fail++; $display("FAIL reset_mid_recover: got q=%0d r=%0d lat=%0d, want q=%0d r=%0d lat=34",
                         quotient, remainder, lat, e.q, e.r);
    end
  endtask

  task automatic test_back_to_back;
    int lat, bc; bit to; logic da; exp_t e;
    logic [31:0] a, b; logic s;
    for (int i = 0; i < 12; i++) begin
      a = $urandom;
      b = (i % 4 == 3) ? $urandom_range(1, 255) : $urandom;
      if (i == 5) b = 32'd0;
      s = $urandom_range(0, 1);
      run_op(a, b, s, 1'b0, lat, bc, to, da);
      e = sb.pop_front();
      n_checks++;
      if (to || quotient !== e.q || remainder !== e.r || div_by_zero !== e.dbz ||
          lat != ((b == 32'd0) ? 2 : 34)) begin
        n_fail++;
        $display("FAIL b2b_%0d: %h/%h s=%b got q=%h r=%h dbz=%b lat=%0d, want q=%h r=%h dbz=%b",
                 i, a, b, s, quotient, remainder, div_by_zero, lat, e.q, e.r, e.dbz);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_div_zero();
    test_signed();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
